key_move_scheduler: RTL



---
 rtl/key_move_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/key_move_scheduler.sv
// key_move_scheduler
// Turns held, debounced direction keys {U,D,R,L} into one-cycle one-hot step
// requests for the position block: one immediate step on press, a hold-off of
// INIT_DELAY clocks, then auto-repeat every STEP_DIV clocks until release.
// Optional build macro: MOVE_ACCEL_EN -- after ACCEL_AFTER repeat steps the
// repeat period halves (minimum 1) until the key is released.
module key_move_scheduler #(
  parameter int CNT_W       = 24,
  parameter int INIT_DELAY  = 4000000,
  parameter int STEP_DIV    = 400000,
  parameter int ACCEL_AFTER = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] keys_raw,
  output logic [3:0] keys,
  output logic       busy,
  output logic [1:0] dir
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_DIV - 1);

  // Reject parameter sets the counter compares cannot represent.
  if (INIT_DELAY < 1 || STEP_DIV < 1 || ACCEL_AFTER < 1 ||
      ((INIT_DELAY - 1) >> CNT_W) != 0 || ((STEP_DIV - 1) >> CNT_W) != 0) begin : g_bad_params
    $error("key_move_scheduler: INIT_DELAY/STEP_DIV/ACCEL_AFTER out of range");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       ks_meta;
  logic [3:0]       ks;
  logic [1:0]       pick_dir;
  logic             held;
  logic [CNT_W-1:0] rep_last;

  function automatic logic [3:0] onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  // Two-flop synchronizer for the asynchronous key levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      ks_meta <= 4'b0;
      ks      <= 4'b0;
    end else begin
      // NOTE: non-blocking assignments make both stages sample the old values
      // on the same edge, giving a true two-stage pipeline.
      ks_meta <= keys_raw;
      ks      <= ks_meta;
    end
  end

  // Fixed priority U > D > R > L among the synchronized keys, and whether the
  // latched key is still down.
  always_comb begin
    // NOTE: default assignment first so every path drives pick_dir (no latch).
    pick_dir = 2'd0;
    if (ks[3])      pick_dir = 2'd3;
    else if (ks[2]) pick_dir = 2'd2;
    else if (ks[1]) pick_dir = 2'd1;
    held = ks[dir];
  end

`ifdef MOVE_ACCEL_EN
  localparam int               FAST_DIV  = ((STEP_DIV >> 1) < 1) ? 1 : (STEP_DIV >> 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
  localparam int               RC_W      = $clog2(ACCEL_AFTER) + 1;
  localparam logic [RC_W-1:0]  ACCEL_N   = RC_W'(ACCEL_AFTER);

  logic [RC_W-1:0] rep_cnt;

  // Repeat period: slow until ACCEL_AFTER repeat steps have been emitted.
  always_comb rep_last = (rep_cnt == ACCEL_N) ? FAST_LAST : STEP_LAST;

  // Count repeat steps (saturating); cleared whenever the FSM is or goes idle.
  always_ff @(posedge clk) begin
    if (rst || !en || state == IDLE) begin
      rep_cnt <= '0;
    end else if (state == REPEAT && held && cnt == rep_last && rep_cnt != ACCEL_N) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  // Repeat period is fixed.
  always_comb rep_last = STEP_LAST;
`endif

  // Press / hold-off / auto-repeat state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every state register gets a reset value; there are no memories
      // here that could legitimately be left unreset.
      state <= IDLE;
      cnt   <= '0;
      keys  <= 4'b0;
      busy  <= 1'b0;
      dir   <= 2'd0;
    end else begin
      keys <= 4'b0;
      if (!en) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ks != 4'b0) begin
              dir   <= pick_dir;
              keys  <= onehot(pick_dir);
              busy  <= 1'b1;
              cnt   <= '0;
              state <= DELAY;
            end
          end
          DELAY: begin
            if (!held) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else if (cnt == DELAY_LAST) begin
              keys  <= onehot(dir);
              cnt   <= '0;
              state <= REPEAT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (!held) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else if (cnt == rep_last) begin
              keys <= onehot(dir);
              cnt  <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
